store_buffer: RTL and testbench

Responder for the pipeline's data-side write path: accepts store requests issued by the memory access stage, queues them in a small FIFO, and asserts `dstbuf_full_o` when it can take no more. Entries drain in order to the L2 interface over a req/ack handshake. Loads that hit a pending line receive byte-masked forwarding data one cycle later. It sits between the core pipeline and the L2 request port, alongside the L1 data cache.

---
 rtl/store_buffer.sv | 192 +++++++++++++++++++
 tb/tb_store_buffer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
//------------------------------------------------------------------------------
// Module  : store_buffer
// Purpose : Queues line-sized stores from the memory access stage and drains
//           them in order to the L2 request port over a req/ack handshake.
//           Loads that hit pending lines get byte-masked forwarding data one
//           cycle later. The youngest store to a line wins each byte.
// Ports   : clk, reset (async, active-high)
//           daddress_i/daccess_i/dwrite_i/dwrite_mask_i/ddata_i : pipeline side
//           dstbuf_full_o                                       : back-pressure
//           fwd_hit_o/fwd_mask_o/fwd_data_o                     : load forwarding
//           l2_req_o/l2_addr_o/l2_mask_o/l2_data_o/l2_ack_i     : L2 drain port
// Config  : STBUF_MERGE_EN - when defined, a store to the line held by the
//           youngest entry merges into it, unless that entry is the head
//           currently being offered to L2.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  daddress_i,
  input  logic         daccess_i,
  input  logic         dwrite_i,
  input  logic [63:0]  dwrite_mask_i,
  input  logic [511:0] ddata_i,
  output logic         dstbuf_full_o,
  output logic         fwd_hit_o,
  output logic [63:0]  fwd_mask_o,
  output logic [511:0] fwd_data_o,
  output logic         l2_req_o,
  output logic [25:0]  l2_addr_o,
  output logic [63:0]  l2_mask_o,
  output logic [511:0] l2_data_o,
  input  logic         l2_ack_i
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [DEPTH-1:0] valid;
  logic [25:0]      ent_addr [DEPTH];
  logic [63:0]      ent_mask [DEPTH];
  logic [511:0]     ent_data [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic [0:0]       state;
  logic [0:0]       state_nxt;

  logic [25:0] line;
  logic        store_req;
  logic        load_req;
  logic        full;
  logic        pop;
  logic        alloc;
  logic        merge;

  assign line      = daddress_i[31:6];
  assign store_req = daccess_i && dwrite_i;
  assign load_req  = daccess_i && !dwrite_i;
  assign full      = (count == (AW+1)'(DEPTH));
  assign pop       = (state == ST_REQ) && l2_ack_i;

`ifdef STBUF_MERGE_EN
  logic [AW-1:0] youngest;
  assign youngest = tail - 1'b1;
  // The head being offered to L2 must stay stable, so it is never a merge target.
  assign merge = store_req && (count != '0) && valid[youngest] &&
                 (ent_addr[youngest] == line) &&
                 !((state == ST_REQ) && (youngest == head));
`else
  assign merge = 1'b0;
`endif

  assign alloc = store_req && !full && !merge;

  // Drain FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Drain FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (count != '0) state_nxt = ST_REQ;
      ST_REQ:  if (l2_ack_i)    state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Drain FSM: outputs (zero outside REQ so reset clears them at once)
  always_comb begin
    l2_req_o  = (state == ST_REQ);
    l2_addr_o = '0;
    l2_mask_o = '0;
    l2_data_o = '0;
    if (state == ST_REQ) begin
      l2_addr_o = ent_addr[head];
      l2_mask_o = ent_mask[head];
      l2_data_o = ent_data[head];
    end
  end

  assign dstbuf_full_o = full;

  // Queue control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (alloc && !pop)      count <= count + 1'b1;
      else if (!alloc && pop) count <= count - 1'b1;
    end
  end

  // Entry payload; qualified by valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (alloc) begin
      ent_addr[tail] <= line;
      ent_mask[tail] <= dwrite_mask_i;
      ent_data[tail] <= ddata_i;
    end
`ifdef STBUF_MERGE_EN
    if (merge) begin
      ent_mask[youngest] <= ent_mask[youngest] | dwrite_mask_i;
      for (int b = 0; b < 64; b++) begin
        if (dwrite_mask_i[b]) ent_data[youngest][b*8 +: 8] <= ddata_i[b*8 +: 8];
      end
    end
`endif
  end

  // Forwarding: walk entries oldest to youngest so younger bytes overwrite.
  logic          hit_c;
  logic [63:0]   mask_c;
  logic [511:0]  data_c;
  logic [AW-1:0] idx;

  always_comb begin
    hit_c  = 1'b0;
    mask_c = '0;
    data_c = '0;
    idx    = '0;
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + i[AW-1:0];
        if (valid[idx] && (ent_addr[idx] == line)) begin
          hit_c = 1'b1;
          for (int b = 0; b < 64; b++) begin
            if (ent_mask[idx][b]) begin
              mask_c[b]          = 1'b1;
              data_c[b*8 +: 8]   = ent_data[idx][b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_hit_o  <= 1'b0;
      fwd_mask_o <= '0;
      fwd_data_o <= '0;
    end else begin
      fwd_hit_o  <= hit_c;
      fwd_mask_o <= mask_c;
      fwd_data_o <= data_c;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none

module tb_store_buffer;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  daddress_i = '0;
  logic         daccess_i = 1'b0;
  logic         dwrite_i = 1'b0;
  logic [63:0]  dwrite_mask_i = '0;
  logic [511:0] ddata_i = '0;
  logic         l2_ack_i = 1'b0;
  logic         dstbuf_full_o, fwd_hit_o, l2_req_o;
  logic [63:0]  fwd_mask_o, l2_mask_o;
  logic [511:0] fwd_data_o, l2_data_o;
  logic [25:0]  l2_addr_o;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .daddress_i(daddress_i), .daccess_i(daccess_i), .dwrite_i(dwrite_i),
    .dwrite_mask_i(dwrite_mask_i), .ddata_i(ddata_i),
    .dstbuf_full_o(dstbuf_full_o),
    .fwd_hit_o(fwd_hit_o), .fwd_mask_o(fwd_mask_o), .fwd_data_o(fwd_data_o),
    .l2_req_o(l2_req_o), .l2_addr_o(l2_addr_o), .l2_mask_o(l2_mask_o),
    .l2_data_o(l2_data_o), .l2_ack_i(l2_ack_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a plain queue of pending lines -------
  typedef struct {
    logic [25:0]  a;
    logic [63:0]  m;
    logic [511:0] d;
  } ent_t;

  ent_t         q[$];
  bit           m_req;
  bit           m_fh;
  logic [63:0]  m_fm;
  logic [511:0] m_fd;
  int           m_n;
  bit           m_was_req;
  bit           m_merged;
  ent_t         m_new;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_req = 0; m_fh = 0; m_fm = '0; m_fd = '0;
    end else begin
      m_n = q.size();
      m_was_req = m_req;
      m_fh = 0; m_fm = '0; m_fd = '0;
      if (daccess_i && !dwrite_i) begin
        foreach (q[i]) begin
          if (q[i].a == daddress_i[31:6]) begin
            m_fh = 1;
            for (int b = 0; b < 64; b++)
              if (q[i].m[b]) begin
                m_fm[b] = 1'b1;
                m_fd[b*8 +: 8] = q[i].d[b*8 +: 8];
              end
          end
        end
      end
      if (daccess_i && dwrite_i) begin
        m_merged = 0;
`ifdef STBUF_MERGE_EN
        // youngest entry is the one on offer to L2 only when it is alone
        if (m_n > 0 && q[m_n-1].a == daddress_i[31:6] && !(m_was_req && m_n == 1)) begin
          q[m_n-1].m = q[m_n-1].m | dwrite_mask_i;
          for (int b = 0; b < 64; b++)
            if (dwrite_mask_i[b]) q[m_n-1].d[b*8 +: 8] = ddata_i[b*8 +: 8];
          m_merged = 1;
        end
`endif
        if (!m_merged && m_n < DEPTH) begin
          m_new.a = daddress_i[31:6]; m_new.m = dwrite_mask_i; m_new.d = ddata_i;
          q.push_back(m_new);
        end
      end
      if (m_was_req && l2_ack_i) void'(q.pop_front());
      // a request is offered the cycle after the buffer is seen non-empty while idle
      m_req = m_was_req ? !l2_ack_i : (m_n > 0);
    end
  end

  // ---------------- compare process ----------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("full", dstbuf_full_o, q.size() == DEPTH);
      chk("l2_req", l2_req_o, m_req);
      chk("l2_addr", l2_addr_o, m_req ? q[0].a : 26'd0);
      chk("l2_mask", l2_mask_o, m_req ? q[0].m : 64'd0);
      chk("l2_data", l2_data_o, m_req ? q[0].d : 512'd0);
      chk("fwd_hit", fwd_hit_o, m_fh);
      chk("fwd_mask", fwd_mask_o, m_fm);
      chk("fwd_data", fwd_data_o, m_fd);
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step(input bit a, input bit w, input logic [31:0] ad,
                      input logic [63:0] m, input logic [511:0] d, input bit ack);
    daccess_i = a; dwrite_i = w; daddress_i = ad;
    dwrite_mask_i = m; ddata_i = d; l2_ack_i = ack;
    @(negedge clk);
  endtask

  task automatic idle(input bit ack);
    step(0, 0, 32'd0, 64'd0, 512'd0, ack);
  endtask

  task automatic wait_req();
    int g = 0;
    while (!l2_req_o && g < 8) begin
      idle(0);
      g++;
    end
    chk("req_timeout", l2_req_o, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 2*DEPTH + 4; k++) idle(1);
    chk("drained_req", l2_req_o, 1'b0);
    chk("drained_cnt", q.size(), 0);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [25:0]  exp_lines [4];
  logic [31:0]  pool [4];
  logic [511:0] dv;

  initial begin
    exp_lines[0] = 26'h80; exp_lines[1] = 26'hC0;
    exp_lines[2] = 26'h100; exp_lines[3] = 26'h140;
    pool[0] = 32'h1000; pool[1] = 32'h1040; pool[2] = 32'h1080; pool[3] = 32'h2000;

    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("rst_req", l2_req_o, 1'b0);
    chk("rst_full", dstbuf_full_o, 1'b0);
    chk("rst_fwd", fwd_hit_o, 1'b0);

    // single store, then drain
    dv = '0; dv[31:0] = 32'hAABBCCDD;
    step(1, 1, 32'h0000_1040, 64'hF, dv, 0);
    chk("t1_req_early", l2_req_o, 1'b0);
    idle(0);
    chk("t1_req", l2_req_o, 1'b1);
    chk("t1_addr", l2_addr_o, 26'h41);
    chk("t1_mask", l2_mask_o, 64'hF);
    chk("t1_data", l2_data_o[31:0], 32'hAABBCCDD);
    idle(1);
    chk("t1_req_off", l2_req_o, 1'b0);
    chk("t1_cnt", q.size(), 0);

    // fill, drop on full, store+ack while full, refill, drain in order
    step(1, 1, 32'h1000, 64'h1, 512'd1, 0);
    step(1, 1, 32'h2000, 64'h2, 512'd2, 0);
    step(1, 1, 32'h3000, 64'h4, 512'd3, 0);
    step(1, 1, 32'h4000, 64'h8, 512'd4, 0);
    chk("t2_full", dstbuf_full_o, 1'b1);
    step(1, 1, 32'h5000, 64'h10, 512'd5, 0);
    chk("t2_drop_cnt", q.size(), 4);
    step(1, 1, 32'h5000, 64'h10, 512'd5, 1);
    chk("t2_ackdrop_cnt", q.size(), 3);
    chk("t2_ackdrop_full", dstbuf_full_o, 1'b0);
    step(1, 1, 32'h5000, 64'h10, 512'd5, 0);
    chk("t2_refill_cnt", q.size(), 4);
    chk("t2_refill_full", dstbuf_full_o, 1'b1);
    for (int k = 0; k < 4; k++) begin
      wait_req();
      chk("t2_order", l2_addr_o, exp_lines[k]);
      idle(1);
    end
    drain();

    // forwarding overlay from two stores to the same line
    dv = '0; dv[31:0] = 32'h11111111;
    step(1, 1, 32'h1040, 64'h0F, dv, 0);
    dv = '0; dv[47:16] = 32'h22222222;
    step(1, 1, 32'h1040, 64'h3C, dv, 0);
    step(1, 0, 32'h1040, 64'h0, 512'd0, 0);
    chk("t3_hit", fwd_hit_o, 1'b1);
    chk("t3_mask", fwd_mask_o, 64'h3F);
    chk("t3_data", fwd_data_o[47:0], 48'h2222_2222_1111);
    idle(0);
    chk("t3_nonload", fwd_hit_o, 1'b0);
    drain();

    // reset in the middle of a request
    step(1, 1, 32'h1000, 64'h1, 512'd7, 0);
    step(1, 1, 32'h2000, 64'h1, 512'd8, 0);
    step(1, 1, 32'h3000, 64'h1, 512'd9, 0);
    wait_req();
    #2 reset = 1'b1;
    #1;
    chk("t4_req", l2_req_o, 1'b0);
    chk("t4_addr", l2_addr_o, 26'd0);
    chk("t4_full", dstbuf_full_o, 1'b0);
    chk("t4_fwd", fwd_mask_o, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle(0);
      chk("t4_noreq", l2_req_o, 1'b0);
    end

    // merge behaviour while head busy on another line
    step(1, 1, 32'h1000, 64'h1, 512'd1, 0);
    idle(0);
    step(1, 1, 32'h2000, 64'h0F, rnd512(), 0);
    step(1, 1, 32'h2000, 64'hF0, rnd512(), 0);
`ifdef STBUF_MERGE_EN
    chk("t5_cnt", q.size(), 2);
`else
    chk("t5_cnt", q.size(), 3);
`endif
    step(1, 0, 32'h2000, 64'h0, 512'd0, 0);
    chk("t5_mask", fwd_mask_o, 64'hFF);
    chk("t5_head", l2_addr_o, 26'h40);
    drain();

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      automatic int sel = $urandom_range(0, 9);
      automatic logic [31:0] ad = pool[$urandom_range(0, 3)] | $urandom_range(0, 63);
      automatic logic [63:0] mk = {$urandom, $urandom};
      if (sel < 4)      step(1, 1, ad, mk, rnd512(), $urandom_range(0, 2) == 0);
      else if (sel < 7) step(1, 0, ad, 64'd0, 512'd0, $urandom_range(0, 2) == 0);
      else              idle($urandom_range(0, 1) == 1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
